trivium_stream: RTL and testbench
=================================

# trivium_stream

Parametrised Trivium keystream generator: takes an 80-bit key and 80-bit IV, runs the 1152-round warm-up, then streams keystream words. Each cycle it computes UNROLL rounds, packs them into W-bit words and buffers them in an internal FIFO. It sits between the key/IV register block and the cipher XOR datapath, and replaces the single-byte, fixed-key generator with its keystream_read strobe.

## Interface
- `W`, 8: keystream word width. Multiple of UNROLL, max 64.
- `UNROLL`, 8: Trivium rounds computed per cycle. Power of two, 1..64; divides 1152 and W.
- `DEPTH`, 4: FIFO depth in words. Power of two, ≥2.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key`  in  80  key; `key[i]` loads state bit s(i+1).
- `iv`  in  80  IV; `iv[i]` loads state bit s(i+94).
- `load`  in  1  start/restart; sampled every cycle in every state.
- `busy`  out  1  high in WARMUP.
- `ks_data`  out  W  head FIFO word; 0 when `ks_valid`=0.
- `ks_valid`  out  1  FIFO non-empty.
- `ks_ready`  in  1  consumer accepts; pop on `ks_valid & ks_ready`.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- The state machine has three states: IDLE, WARMUP and RUN.
  - Reset enters IDLE.
  - `load` moves any state to WARMUP.
  - WARMUP moves to RUN after 1152/UNROLL cycles.
- Load edge:
  - s1..s80 = key; s81..s93 = 0.
  - s94..s173 = iv; s174..s285 = 0.
  - s286..s288 = 1.
  - Clears the warm-up counter, pack register, pack counter and FIFO.
- Round (standard Trivium):
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288, and z = t1^t2^t3.
  - Then t1 ^= s91&s92^s171, t2 ^= s175&s176^s264, t3 ^= s286&s287^s69.
  - Shift in: s1 ← t3, s94 ← t1, s178 ← t2.
  - UNROLL rounds are chained combinationally within one cycle.
- WARMUP: rounds run unconditionally and z is discarded.
- RUN, advance condition: the core advances only when `!full || pop`. When stalled, the state, pack register and pack counter hold.
- Packing:
  - Output is LSB-first: first z of a word goes to bit 0, and the round-r output of a cycle goes to bit (cnt*UNROLL + r).
  - After W/UNROLL advancing cycles the complete word is pushed.
- FIFO:
  - Show-ahead; a push and a pop in the same cycle leave `level` unchanged.
  - Overflow is impossible by construction.
  - An empty FIFO ignores pop.
- Arithmetic:
  - The warm-up counter is sized for 1152/UNROLL.
  - The pack counter wraps modulo W/UNROLL.
- Simultaneous events:
  - `load` with a pop in the same cycle: the handshake completes (the word counts as delivered), then the flush wins and `level` = 0.
  - `load` during WARMUP restarts the warm-up count from 0.
- Reset mid-operation returns everything to the reset values below. IDLE holds until `load`.

## Timing
- Reset values:
  - `busy`=0, `ks_valid`=0, `ks_data`=0, `level`=0.
  - State register all zero; FIFO pointers and counters 0.
- Load at edge E0:
  - `busy`=1 after E0.
  - WARMUP spans edges E1..E(1152/UNROLL); `busy`=0 after the last of them.
- First word:
  - Pushed W/UNROLL edges later; `ks_valid`=1 after that push edge.
  - Total `load`→`ks_valid` latency is 1152/UNROLL + W/UNROLL cycles (145 at W=8, UNROLL=8; 1160 at W=8, UNROLL=1).
- Throughput: one word per W/UNROLL cycles sustained while `ks_ready`=1.
- `ks_valid` and `ks_data` come straight from registers and FIFO storage, with no combinational path from `ks_ready`.

## Configuration
- Macro `TRIVIUM_WORD_COUNT_EN`.
- Defined:
  - Adds output port `word_count[31:0]`, counting popped words since the last `load` or `rst`.
  - Cleared on `load`, except that a pop in the same cycle as `load` leaves the counter at 1 (consistent with the word counting as delivered).
  - Saturates at 0xFFFFFFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Golden vector:
  - Stimulus: key=0, iv=0, W=8, UNROLL=8, `ks_ready`=1.
  - Required: `ks_valid` rises exactly 145 cycles after the `load` edge; the first four words are 0xFB, 0xE0, 0xBF, 0x26.
  - The full stream must match the bit-serial golden model for 64 words.
- Parameter sweep:
  - Stimulus: (W,UNROLL) = (8,1), (32,8), (64,64) with a random key/IV.
  - Required: identical bitstream to the model; latency 1160, 148 and 19 cycles respectively.
- Backpressure:
  - Stimulus: hold `ks_ready`=0.
  - Required: `level` reaches DEPTH and the state freezes. On release, the stream continues with no lost or duplicated bits; random `ks_ready` toggling matches the model.
- Restart:
  - Stimulus: `load` during WARMUP, and `load` in RUN with `level`=3 and a simultaneous pop.
  - Required: `level`=0 and `ks_valid`=0 the next cycle, the warm-up restarts, and the new-key stream is correct.
- Reset mid-run:
  - Stimulus: assert `rst` asynchronously between edges during RUN.
  - Required: all outputs are 0 immediately; no output until the next `load`.
- Macro on:
  - Stimulus: pop 5 words, then `load`.
  - Required: `word_count` reads 5, then 0 the cycle after `load`.

Source files
------------

// File: rtl/trivium_stream.sv
// Trivium keystream generator: 1152-round warm-up, then UNROLL rounds per cycle packed LSB-first into
// W-bit words and buffered in a show-ahead FIFO. Define TRIVIUM_WORD_COUNT_EN to add the word_count output.
module trivium_stream #(
   parameter int W      = 8,
   parameter int UNROLL = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [79:0]            key,
   input  logic [79:0]            iv,
   input  logic                   load,
   output logic                   busy,
   output logic [W-1:0]           ks_data,
   output logic                   ks_valid,
   input  logic                   ks_ready,
   output logic [$clog2(DEPTH):0] level
`ifdef TRIVIUM_WORD_COUNT_EN
   ,
   output logic [31:0]            word_count
`endif
);

   localparam int WARM_CYCLES = 1152 / UNROLL;
   localparam int WC_W        = $clog2(WARM_CYCLES);
   localparam int PACK_N      = W / UNROLL;
   localparam int PC_W        = (PACK_N > 1) ? $clog2(PACK_N) : 1;
   localparam int AW          = $clog2(DEPTH);
   localparam int LW          = AW + 1;

   localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARM_CYCLES - 1);
   localparam logic [PC_W-1:0] PACK_LAST = PC_W'(PACK_N - 1);

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      RUN
   } state_t;

   state_t            state, state_d;
   logic [287:0]      s, s_next, st, s_init;
   logic [UNROLL-1:0] z_vec;
   logic              t1, t2, t3;
   logic [WC_W-1:0]   warm_cnt;
   logic [W-1:0]      pack, pack_d;
   logic [PC_W-1:0]   pack_cnt;
   logic              advance, push, pop, full;

   logic [W-1:0]      mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     count;

   // s[i-1] holds Trivium state bit s(i)
   assign s_init = {3'b111, 112'b0, iv, 13'b0, key};

   always_comb begin
      // NOTE: blocking assignments here chain the UNROLL rounds through one combinational cone.
      st    = s;
      z_vec = '0;
      t1    = 1'b0;
      t2    = 1'b0;
      t3    = 1'b0;
      for (int r = 0; r < UNROLL; r++) begin
         t1       = st[65] ^ st[92];
         t2       = st[161] ^ st[176];
         t3       = st[242] ^ st[287];
         z_vec[r] = t1 ^ t2 ^ t3;
         t1       = t1 ^ (st[90] & st[91]) ^ st[170];
         t2       = t2 ^ (st[174] & st[175]) ^ st[263];
         t3       = t3 ^ (st[285] & st[286]) ^ st[68];
         st       = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
      end
      s_next = st;
   end

   assign pop    = ks_valid & ks_ready;
   assign full   = (count == LW'(DEPTH));
   assign pack_d = pack | (W'(z_vec) << (pack_cnt * UNROLL));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      advance = 1'b0;
      unique case (state)
         IDLE: ;
         WARMUP: begin
            advance = 1'b1;
            if (warm_cnt == WARM_LAST) state_d = RUN;
         end
         RUN:     advance = !full || pop;
         default: state_d = IDLE;
      endcase
      if (load) state_d = WARMUP;
   end

   assign push = (state == RUN) && advance && (pack_cnt == PACK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s        <= '0;
         warm_cnt <= '0;
         pack     <= '0;
         pack_cnt <= '0;
      end else if (load) begin
         s        <= s_init;
         warm_cnt <= '0;
         pack     <= '0;
         pack_cnt <= '0;
      end else begin
         if (advance) s <= s_next;
         if (state == WARMUP)
            warm_cnt <= (warm_cnt == WARM_LAST) ? '0 : warm_cnt + WC_W'(1);
         if (state == RUN && advance) begin
            // pack is cleared on push so the next word can be OR-assembled
            pack     <= push ? '0 : pack_d;
            pack_cnt <= (pack_cnt == PACK_LAST) ? '0 : pack_cnt + PC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (load) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: FIFO storage has no reset; count gates every read so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pack_d;
   end

   assign ks_valid = (count != '0);
   assign ks_data  = ks_valid ? mem[rd_ptr] : '0;
   assign level    = count;
   assign busy     = (state == WARMUP);

`ifdef TRIVIUM_WORD_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                word_count <= '0;
      else if (load)                          word_count <= pop ? 32'd1 : 32'd0;
      else if (pop && word_count != '1)       word_count <= word_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// Self-checking bench for trivium_stream: four parameterisations share stimulus and are compared
// against a bit-serial Trivium model plus hand-computed golden bytes and latencies.
module tb_trivium_stream;

   localparam int GOLD_BITS = 65536;

   logic        clk = 1'b0;
   logic        rst;
   logic [79:0] key, iv;
   logic        load;
   logic        ks_ready;

   logic [3:0]  busy, vld;
   logic [7:0]  d0, d1;
   logic [31:0] d2;
   logic [63:0] d3;
   logic [63:0] dat [4];
   logic [2:0]  lvl [4];
`ifdef TRIVIUM_WORD_COUNT_EN
   logic [31:0] wc [4];
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc;
   int          widx [4];
   int          first_lat [4];
   logic [7:0]  first_words [4];
   bit          gold [GOLD_BITS];
   logic [1:288] ms;

   always #5 clk = ~clk;

   trivium_stream #(.W(8), .UNROLL(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .key(key), .iv(iv), .load(load), .busy(busy[0]),
      .ks_data(d0), .ks_valid(vld[0]), .ks_ready(ks_ready), .level(lvl[0])
`ifdef TRIVIUM_WORD_COUNT_EN
      , .word_count(wc[0])
`endif
   );
   trivium_stream #(.W(8), .UNROLL(1), .DEPTH(4)) dut_u1 (
      .clk(clk), .rst(rst), .key(key), .iv(iv), .load(load), .busy(busy[1]),
      .ks_data(d1), .ks_valid(vld[1]), .ks_ready(ks_ready), .level(lvl[1])
`ifdef TRIVIUM_WORD_COUNT_EN
      , .word_count(wc[1])
`endif
   );
   trivium_stream #(.W(32), .UNROLL(8), .DEPTH(4)) dut_w32 (
      .clk(clk), .rst(rst), .key(key), .iv(iv), .load(load), .busy(busy[2]),
      .ks_data(d2), .ks_valid(vld[2]), .ks_ready(ks_ready), .level(lvl[2])
`ifdef TRIVIUM_WORD_COUNT_EN
      , .word_count(wc[2])
`endif
   );
   trivium_stream #(.W(64), .UNROLL(64), .DEPTH(4)) dut_w64 (
      .clk(clk), .rst(rst), .key(key), .iv(iv), .load(load), .busy(busy[3]),
      .ks_data(d3), .ks_valid(vld[3]), .ks_ready(ks_ready), .level(lvl[3])
`ifdef TRIVIUM_WORD_COUNT_EN
      , .word_count(wc[3])
`endif
   );

   assign dat[0] = {56'b0, d0};
   assign dat[1] = {56'b0, d1};
   assign dat[2] = {32'b0, d2};
   assign dat[3] = d3;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int wid(input int i);
      case (i)
         0, 1:    return 8;
         2:       return 32;
         default: return 64;
      endcase
   endfunction

   // Bit-serial reference, written with the 1-based state numbering of the cipher description
   task automatic model_step(output bit z);
      bit a, b, c;
      a  = ms[66] ^ ms[93];
      b  = ms[162] ^ ms[177];
      c  = ms[243] ^ ms[288];
      z  = a ^ b ^ c;
      a  = a ^ (ms[91] & ms[92]) ^ ms[171];
      b  = b ^ (ms[175] & ms[176]) ^ ms[264];
      c  = c ^ (ms[286] & ms[287]) ^ ms[69];
      ms = {c, ms[1:92], a, ms[94:176], b, ms[178:287]};
   endtask

   task automatic model_load(input logic [79:0] k, input logic [79:0] v);
      bit z;
      ms = '0;
      for (int i = 0; i < 80; i++) begin
         ms[i + 1]  = k[i];
         ms[i + 94] = v[i];
      end
      ms[286] = 1'b1;
      ms[287] = 1'b1;
      ms[288] = 1'b1;
      for (int i = 0; i < 1152; i++) model_step(z);
      for (int i = 0; i < GOLD_BITS; i++) begin
         model_step(z);
         gold[i] = z;
      end
   endtask

   function automatic logic [63:0] gold_word(input int w, input int k);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < w; b++) r[b] = gold[k * w + b];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Called at a sample point after ks_ready is set: every word popped at the next edge is checked
   task automatic sample_all();
      for (int i = 0; i < 4; i++) begin
         if (vld[i]) begin
            if (first_lat[i] < 0) first_lat[i] = cyc;
            if (ks_ready) begin
               if (i == 0 && widx[0] < 4) first_words[widx[0]] = dat[0][7:0];
               if ((widx[i] + 1) * wid(i) <= GOLD_BITS)
                  check($sformatf("stream%0d_word%0d", i, widx[i]), dat[i], gold_word(wid(i), widx[i]));
               widx[i]++;
            end
         end
      end
   endtask

   task automatic start(input logic [79:0] k, input logic [79:0] v);
      key  = k;
      iv   = v;
      load = 1'b1;
      sample_all();
      model_load(k, v);
      for (int i = 0; i < 4; i++) begin
         widx[i]      = 0;
         first_lat[i] = -1;
      end
      tick();
      load = 1'b0;
      cyc  = 0;
   endtask

   // mode 0: ready held high, 1: random ready, 2: ready held low
   task automatic run(input int n, input int mode);
      for (int c = 0; c < n; c++) begin
         case (mode)
            0:       ks_ready = 1'b1;
            1:       ks_ready = 1'($urandom_range(0, 1));
            default: ks_ready = 1'b0;
         endcase
         sample_all();
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] head;
      int          g;
      int          seen;
      rst      = 1'b1;
      load     = 1'b0;
      ks_ready = 1'b0;
      key      = '0;
      iv       = '0;
      cyc      = 0;
      for (int i = 0; i < 4; i++) begin
         widx[i]      = 0;
         first_lat[i] = -1;
      end
      #1;
      check("reset_busy",  busy[0], 0);
      check("reset_valid", vld[0],  0);
      check("reset_data",  dat[0],  0);
      check("reset_level", lvl[0],  0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Golden vector and latency of every parameterisation
      start(80'h0, 80'h0);
      check("busy_after_load", busy[0], 1);
      run(1200, 0);
      check("golden_byte0", first_words[0], 8'hFB);
      check("golden_byte1", first_words[1], 8'hE0);
      check("golden_byte2", first_words[2], 8'hBF);
      check("golden_byte3", first_words[3], 8'h26);
      check("lat_w8_u8",   first_lat[0], 145);
      check("lat_w8_u1",   first_lat[1], 1160);
      check("lat_w32_u8",  first_lat[2], 148);
      check("lat_w64_u64", first_lat[3], 19);
      check("golden_64_words", widx[0] >= 64, 1);
      check("busy_in_run", busy[0], 0);

      // Random key/IV with random ready, then hard backpressure
      start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)});
      run(1250, 1);
      for (int i = 0; i < 4; i++) check($sformatf("sweep%0d_words_seen", i), widx[i] > 0, 1);
      run(20, 2);
      check("bp_level_full", lvl[0], 4);
      head = dat[0];
      run(10, 2);
      check("bp_level_hold", lvl[0], 4);
      check("bp_head_hold",  dat[0], head);
      check("bp_valid_hold", vld[0], 1);
      run(100, 0);

`ifdef TRIVIUM_WORD_COUNT_EN
      ks_ready = 1'b0;
      start(80'h0123_4567_89AB_CDEF_0011, 80'hFEDC_BA98_7654_3210_ABCD);
      check("wc_cleared", wc[0], 0);
      run(150, 2);
      run(5, 0);
      ks_ready = 1'b0;
      check("wc_five", wc[0], 5);
      start(80'h0123_4567_89AB_CDEF_0011, 80'hFEDC_BA98_7654_3210_ABCD);
      check("wc_after_load", wc[0], 0);
`endif

      // Restart during warm-up
      start(80'hA5A5_5A5A_0F0F_F0F0_1234, 80'h0000_1111_2222_3333_4444);
      run(50, 0);
      check("warmup_busy", busy[0], 1);
      start(80'h8000_0000_0000_0000_0001, 80'h1357_9BDF_0246_8ACE_FFFF);
      check("rewarm_busy", busy[0], 1);
      run(200, 0);
      check("rewarm_latency", first_lat[0], 145);
      check("rewarm_words", widx[0] > 40, 1);

      // Load in RUN with level 3 and a simultaneous pop
      ks_ready = 1'b0;
      g = 0;
      while (lvl[0] != 3 && g < 10) begin
         sample_all();
         tick();
         g++;
      end
      check("level3_reached", lvl[0], 3);
      ks_ready = 1'b1;
      start(80'hDEAD_BEEF_CAFE_F00D_7777, 80'h2468_ACE0_1357_9BDF_8888);
      check("flush_level", lvl[0], 0);
      check("flush_valid", vld[0], 0);
      check("flush_data",  dat[0], 0);
      check("flush_busy",  busy[0], 1);
`ifdef TRIVIUM_WORD_COUNT_EN
      check("wc_load_with_pop", wc[0], 1);
`endif
      run(200, 0);
      check("reload_latency", first_lat[0], 145);
      check("reload_words", widx[0] > 40, 1);

      // Asynchronous reset between edges during RUN
      run(20, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_busy",  busy[0], 0);
      check("arst_valid", vld,     0);
      check("arst_data",  dat[0],  0);
      check("arst_level", lvl[0],  0);
      #3 rst = 1'b0;
      seen = 0;
      ks_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (|vld || |busy) seen++;
      end
      check("idle_after_reset", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
